// File: rtl/div_pkg.sv
// Shared types and widths for the divider error monitor.
// The FSM state enum lives here so the top and the bench agree on one encoding.
package div_pkg;

  localparam int X_W  = 16;
  localparam int Y_W  = 8;
  localparam int ED_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_err_calc.sv
// Combinational per-sample classification: invalid flag, quotient error distance
// and approximate/exact mismatch flag.
module div_err_calc
  import div_pkg::*;
(
  input  logic [X_W-1:0]  x_i,
  input  logic [Y_W-1:0]  y_i,
  input  logic [Y_W-1:0]  q_app_i,
  input  logic [Y_W-1:0]  r_app_i,
  input  logic [Y_W-1:0]  q_ex_i,
  input  logic [Y_W-1:0]  r_ex_i,
  output logic            invalid_o,
  output logic [ED_W-1:0] ed_o,
  output logic            mismatch_o
);

  logic signed [Y_W:0] diff;

  always_comb begin
    // x >= y*256 is the same test as x[15:8] >= y; it also covers y == 0
    invalid_o  = (y_i == '0) || (x_i >= {y_i, 8'h00});
    diff       = $signed({1'b0, q_ex_i}) - $signed({1'b0, q_app_i});
    ed_o       = diff[Y_W] ? ED_W'(-diff) : diff[ED_W-1:0];
    mismatch_o = (ed_o != '0) || (r_app_i != r_ex_i);
  end

endmodule

// File: rtl/div_err_monitor.sv
// Collects error statistics of an approximate divider against an exact one over
// a run of n_samples accepted samples, through a two-stage pipeline.
module div_err_monitor
  import div_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      n_samples,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic [Y_W-1:0]        q_app,
  input  logic [Y_W-1:0]        r_app,
  input  logic [Y_W-1:0]        q_ex,
  input  logic [Y_W-1:0]        r_ex,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      inv_cnt,
  output logic [CNT_W+ED_W-1:0] sum_ed,
  output logic [ED_W-1:0]       max_ed,
  output div_state_e            dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state (never on in_valid) and the source may
  // raise in_valid without waiting for in_ready.

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [CNT_W-1:0]      acc_q, acc_d;
  logic                  s1_valid_q, s1_inv_q, s1_mis_q;
  logic [ED_W-1:0]       s1_ed_q;
  logic [CNT_W-1:0]      err_q, err_d, inv_q, inv_d;
  logic [CNT_W+ED_W-1:0] sum_q, sum_d;
  logic [ED_W-1:0]       max_q, max_d;
  logic                  c_inv, c_mis;
  logic [ED_W-1:0]       c_ed;
  logic                  hs, start_clr;

  div_err_calc u_calc (
    .x_i        (x),
    .y_i        (y),
    .q_app_i    (q_app),
    .r_app_i    (r_app),
    .q_ex_i     (q_ex),
    .r_ex_i     (r_ex),
    .invalid_o  (c_inv),
    .ed_o       (c_ed),
    .mismatch_o (c_mis)
  );

  assign in_ready  = (state_q == ST_RUN);
  assign hs        = in_valid && in_ready;
  assign start_clr = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d     = n_samples;
          acc_d   = '0;
          state_d = (n_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (hs) begin
          acc_d = acc_q + CNT_W'(1);
          // Leaving RUN right after the last handshake caps accepted samples at n
          if (acc_q == n_q - CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    inv_d = inv_q;
    sum_d = sum_q;
    max_d = max_q;
    if (start_clr) begin
      err_d = '0;
      inv_d = '0;
      sum_d = '0;
      max_d = '0;
    end else if (s1_valid_q) begin
      if (s1_inv_q) begin
        inv_d = inv_q + CNT_W'(1);
      end else begin
        sum_d = sum_q + {{CNT_W{1'b0}}, s1_ed_q};
        if (s1_ed_q > max_q) max_d = s1_ed_q;
        if (s1_mis_q) err_d = err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_mis_q   <= 1'b0;
      s1_ed_q    <= '0;
      err_q      <= '0;
      inv_q      <= '0;
      sum_q      <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      s1_valid_q <= hs;
      if (hs) begin
        s1_inv_q <= c_inv;
        s1_mis_q <= c_mis;
        s1_ed_q  <= c_ed;
      end
      err_q      <= err_d;
      inv_q      <= inv_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
    end
  end

  assign err_cnt = err_q;
  assign inv_cnt = inv_q;
  assign sum_ed  = sum_q;
  assign max_ed  = max_q;

endmodule

// File: doc/div_err_monitor.md
DIV_ERR_MONITOR -- requirements
Module: div_err_monitor

Interface
REQ-001 Parameter: CNT_W, default 16, width of the sample-count request and all event counters.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  in  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 Port: start  in  1  single-cycle pulse that begins a measurement run.
REQ-005 Port: n_samples  in  CNT_W  number of samples to accept in the run; sampled on start.
REQ-006 Port: in_valid  in  1  sample present on x/y/q_app/r_app/q_ex/r_ex.
REQ-007 Port: in_ready  out  1  monitor accepts a sample this cycle.
REQ-008 Port: x  in  16  dividend.
REQ-009 Port: y  in  8  divisor.
REQ-010 Port: q_app, r_app  in  8 each  quotient and remainder from the approximate array divider.
REQ-011 Port: q_ex, r_ex  in  8 each  quotient and remainder from the exact array divider.
REQ-012 Port: busy  out  1  run in progress.
REQ-013 Port: done  out  1  statistics final and stable.
REQ-014 Port: err_cnt, inv_cnt  out  CNT_W each  erroneous-sample count and invalid-sample count.
REQ-015 Port: sum_ed  out  CNT_W+8  accumulated quotient error distance.
REQ-016 Port: max_ed  out  8  maximum quotient error distance.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN and DONE; the monitor SHALL reset to IDLE.
REQ-018 IDLE/DONE + start: SHALL clear all statistics and latch n_samples; next state SHALL be RUN, or DONE when n_samples==0.
REQ-019 in_ready SHALL be 1 only in RUN; handshake is in_valid && in_ready, and the number of accepted samples SHALL never exceed n_samples.
REQ-020 RUN SHALL transition to DRAIN in the cycle after the n_samples-th handshake; DRAIN SHALL transition to DONE once the pipeline is empty.
REQ-021 A start received in RUN or DRAIN SHALL be ignored.
REQ-022 Pipeline: stage 1 registers the accepted sample together with its valid, invalid and ed flags; stage 2 updates the statistics; a sample accepted at edge t SHALL be reflected in the outputs after edge t+2.
REQ-023 Invalid sample: y==0 or x[15:8]>=y (quotient overflows 8 bits) -> inv_cnt+1 only; invalid samples are excluded from all other statistics.
REQ-024 ed = |q_ex - q_app|, computed at 9-bit signed width and reduced to an 8-bit magnitude.
REQ-025 Valid sample: sum_ed += ed; max_ed = max(max_ed, ed); err_cnt+1 if ed!=0 or r_app!=r_ex.
REQ-026 sum_ed width CNT_W+8 SHALL be overflow-free (2^CNT_W-1 samples x 255); err_cnt and inv_cnt cannot exceed n_samples.
REQ-027 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 in DONE only and held until the next start.
REQ-028 Statistics outputs SHALL be registered and SHALL change only in stage 2 or on a start clear.

Reset
REQ-029 With rst_n==0 at an edge: state=IDLE, pipeline valids=0, in_ready=0, busy=0, done=0, and all statistics=0.
REQ-030 Reset asserted mid-run SHALL abort the run, discard any in-flight samples, and take effect on the sampling edge.

Structure
REQ-031 A shared package div_pkg SHALL hold the FSM state enum, the operand widths (16/8) and the ED_W=8 constant.
REQ-032 One combinational sub-module, div_err_calc, SHALL compute the invalid flag, ed and the mismatch flag.

Verification
REQ-033 n_samples=3 with samples (x=100,y=7,q_app=14,r_app=2,q_ex=14,r_ex=2) x3 -> done, err_cnt=0, inv_cnt=0, sum_ed=0, max_ed=0.
REQ-034 Samples with q_app/q_ex pairs 12/14, 17/14, 14/14 (y=7, matching r) -> err_cnt=2, sum_ed=5, max_ed=3.
REQ-035 Sample with y=0, then sample with x=16'h0900 and y=8 -> inv_cnt=2, err_cnt=0, sum_ed=0.
REQ-036 n_samples=0 with start -> done=1 on the next cycle, in_ready never asserted, all statistics 0.
REQ-037 in_valid held at 1 for 10 cycles with n_samples=4 -> exactly 4 handshakes, in_ready=0 afterwards, done asserted 3 cycles after the last handshake.
REQ-038 rst_n pulsed low after 2 of 5 samples -> IDLE with all outputs 0; a new start runs correctly.
